alu_arbiter: RTL
================

# alu_arbiter

Shares the single 32-bit ALU between two requesters (e.g. address-generation and execute paths) using valid/ready handshakes on both request and response sides. It serialises one operation at a time, round-robin between requesters, registering operands into the ALU and capturing `ALUResult`/`Zero` into a held response. Operations with illegal opcodes are flagged with an error instead of being executed.

## Interface
- `RESET_PRIO`, default 0 — requester that holds priority after reset (0 or 1).

- `clk`  in  1  — sole clock, rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `ReqValid`  in  2  — bit i: requester i presents an operation.
- `ReqReady`  out  2  — bit i: operation of requester i is accepted this cycle.
- `ReqSrcA`  in  64  — `{req1, req0}` 32-bit A operands.
- `ReqSrcB`  in  64  — `{req1, req0}` 32-bit B operands.
- `ReqALUControl`  in  6  — `{req1, req0}` 3-bit opcodes.
- `RspValid`  out  2  — bit i: response for requester i is available.
- `RspReady`  in  2  — bit i: requester i consumes its response.
- `RspResult`  out  32  — held result, shared by both requesters (qualified by `RspValid`).
- `RspZero`  out  1  — held ALU `Zero` flag.
- `RspErr`  out  1  — opcode was 110 or 111; result forced to 0 and `RspZero` to 1.
- `SrcA`, `SrcB`  out  32 each — to ALU, driven from the operand register.
- `ALUControl`  out  3  — to ALU, driven from the operand register.
- `ALUResult`  in  32; `Zero`  in  1 — from ALU.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: Grant (1b), Prio (1b), the operand register (A, B, op), and the result register (result, zero, err).
- Winner selection in IDLE, combinational:
  - If `ReqValid[Prio]`, the winner is Prio.
  - Else, if the other valid bit is set, the winner is the other requester.
  - Else there is no winner.
- `ReqReady[i]` = (state==IDLE) && winner==i. At most one bit is set. `ReqReady` never depends on `RspReady`.
- IDLE, on accept:
  - Latch the winner's operands and opcode into the operand register.
  - Set Grant := winner.
  - Go to EXEC.
  - With no valid requests, stay in IDLE.
- EXEC (exactly one cycle):
  - The ALU sees the operand register.
  - For a legal opcode (000–101), capture `ALUResult` and `Zero`, with err=0.
  - For opcode 110/111, capture result=0, zero=1, err=1. The `ALUResult` value is ignored.
  - Go to RESP.
- RESP:
  - `RspValid[Grant]`=1 and the other bit is 0. `RspResult`/`RspZero`/`RspErr` are stable.
  - On `RspReady[Grant]`: Prio := ~Grant, go to IDLE. `RspReady` of the non-granted requester is ignored.
  - Without `RspReady[Grant]`, hold indefinitely.
- Outside EXEC, `SrcA`/`SrcB`/`ALUControl` keep their last latched values; they change only on accept.
- Fairness: Prio flips after each completed response, so a continuously requesting requester waits at most one operation.

## Timing
- Reset (async assert, any state) forces:
  - State to IDLE and Prio to `RESET_PRIO`.
  - Operand register, result register and Grant to 0.
  - `RspValid`=00, `RspResult`=0, `RspZero`=0, `RspErr`=0, `SrcA`=`SrcB`=0, `ALUControl`=000.
- An in-flight operation is discarded on reset; no response is produced.
- `ReqReady` is a function of reset state and `ReqValid` only. After reset release with `ReqValid`=11, `ReqReady` equals the one-hot of `RESET_PRIO`.
- Latency: accept at edge N (end of cycle N), EXEC in cycle N+1, `RspValid` high from cycle N+2.
- With `RspReady` held high, the response handshake completes in cycle N+2. The next accept is possible in cycle N+3, so peak throughput is one op per 3 cycles.
- A request arriving while busy waits with `ReqValid` high and `ReqReady` low. The requester must hold its operands stable until accepted.
- If `RspReady` is high in IDLE/EXEC, it has no effect.

## Test plan
- Reset: with `RESET_PRIO`=0, hold `reset_n` low → all outputs at reset values.
  - Release with `ReqValid`=11 → `ReqReady`=01 in the first cycle.
- Single op: req0 sends A=5, B=7, op=001, with `RspReady`=11.
  - → `RspValid`=01 two cycles after accept, `RspResult`=0xFFFFFFFE, `RspZero`=0, `RspErr`=0.
  - → back in IDLE, Prio=1.
- Round-robin: both requesters stream back-to-back.
  - req0 sends op=000, A=1, B=1; req1 sends op=100, B=0.
  - → grants alternate 0,1,0,1.
  - → results 2, then 0 with `RspZero`=1.
  - → no requester is granted twice in a row while the other is valid.
- Backpressure: hold `RspReady[1]`=0 for 5 cycles during a req1 response.
  - → `RspValid`=10 and the result stay stable; `ReqReady`=00 while `ReqValid[0]`=1.
  - → req0 is accepted the cycle after `RspReady[1]` rises and the handshake completes.
- Illegal opcode: req1 sends op=111 with A=B=0xFFFFFFFF.
  - → `RspErr`=1, `RspResult`=0, `RspZero`=1, grant advances normally.
- Reset mid-op: assert `reset_n` low during EXEC and again during a stalled RESP.
  - → `RspValid` drops to 00 immediately (asynchronously).
  - → no response for the discarded op after release; Prio = `RESET_PRIO`.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Signal bundle for the shared-ALU arbiter: two requesters' request/response
// handshakes plus the operand/result path to the single ALU.
interface alu_arbiter_if;
   logic [1:0]  ReqValid;
   logic [1:0]  ReqReady;
   logic [63:0] ReqSrcA;
   logic [63:0] ReqSrcB;
   logic [5:0]  ReqALUControl;
   logic [1:0]  RspValid;
   logic [1:0]  RspReady;
   logic [31:0] RspResult;
   logic        RspZero;
   logic        RspErr;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic [31:0] ALUResult;
   logic        Zero;

   modport slave (
      input  ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, RspReady, ALUResult, Zero,
      output ReqReady, RspValid, RspResult, RspZero, RspErr, SrcA, SrcB, ALUControl
   );

   modport master (
      output ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, RspReady, ALUResult, Zero,
      input  ReqReady, RspValid, RspResult, RspZero, RspErr, SrcA, SrcB, ALUControl
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter serialising two requesters onto one 32-bit ALU:
// accept -> one execute cycle -> held response until the winner consumes it.
module alu_arbiter #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_grant;
   logic        r_prio;
   logic [31:0] r_src_a;
   logic [31:0] r_src_b;
   logic [2:0]  r_op;
   logic [31:0] r_result;
   logic        r_zero;
   logic        r_err;
   logic        w_winner;
   logic        w_win_valid;
   logic        w_accept;
   logic        w_rsp_done;
   logic        w_illegal;

   // Winner selection: the priority holder first, otherwise the other requester.
   always_comb begin
      w_winner    = r_prio;
      w_win_valid = 1'b0;
      if (bus.ReqValid[r_prio]) begin
         w_winner    = r_prio;
         w_win_valid = 1'b1;
      end else if (bus.ReqValid[~r_prio]) begin
         w_winner    = ~r_prio;
         w_win_valid = 1'b1;
      end else begin
         w_winner    = r_prio;
         w_win_valid = 1'b0;
      end
   end

   assign w_accept   = (r_state == S_IDLE) && w_win_valid;
   assign w_rsp_done = (r_state == S_RESP) && bus.RspReady[r_grant];
   assign w_illegal  = (r_op[2:1] == 2'b11);

   // Next-state logic for the accept/execute/respond sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_win_valid) w_state_nxt = S_EXEC;
            else             w_state_nxt = S_IDLE;
         end
         S_EXEC: w_state_nxt = S_RESP;
         S_RESP: begin
            if (bus.RspReady[r_grant]) w_state_nxt = S_IDLE;
            else                       w_state_nxt = S_RESP;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Operand register and grant load only when a request is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant <= 1'b0;
         r_src_a <= 32'd0;
         r_src_b <= 32'd0;
         r_op    <= 3'd0;
      end else if (w_accept) begin
         r_grant <= w_winner;
         r_src_a <= w_winner ? bus.ReqSrcA[63:32]      : bus.ReqSrcA[31:0];
         r_src_b <= w_winner ? bus.ReqSrcB[63:32]      : bus.ReqSrcB[31:0];
         r_op    <= w_winner ? bus.ReqALUControl[5:3]  : bus.ReqALUControl[2:0];
      end
   end

   // Priority passes to the other requester once a response completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_prio <= RESET_PRIO;
      else if (w_rsp_done) r_prio <= ~r_grant;
   end

   // Result capture during the single execute cycle; illegal opcodes bypass the ALU.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result <= 32'd0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else if (r_state == S_EXEC) begin
         if (w_illegal) begin
            r_result <= 32'd0;
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
         end else begin
            r_result <= bus.ALUResult;
            r_zero   <= bus.Zero;
            r_err    <= 1'b0;
         end
      end
   end

   assign bus.ReqReady   = w_accept ? (2'b01 << w_winner) : 2'b00;
   assign bus.RspValid   = (r_state == S_RESP) ? (2'b01 << r_grant) : 2'b00;
   assign bus.RspResult  = r_result;
   assign bus.RspZero    = r_zero;
   assign bus.RspErr     = r_err;
   assign bus.SrcA       = r_src_a;
   assign bus.SrcB       = r_src_b;
   assign bus.ALUControl = r_op;
endmodule
